sntc_ldpc_cword_serializer: RTL and testbench

Downstream of the LDPC encoder wrapper. Captures each full NN-bit encoded codeword once the encoder's syndrome check marks it valid, then streams it out as OW-bit beats over a valid/ready handshake toward the channel/packing logic. Codewords that fail the syndrome check are dropped and counted. Single-entry buffered, with back-to-back codeword throughput.

---
 rtl/sntc_ldpc_cword_serializer.sv | 91 +++++++++
 tb/tb_sntc_ldpc_cword_serializer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/sntc_ldpc_cword_serializer.sv
// Holds one syndrome-checked LDPC codeword and streams it as OW-bit beats over valid/ready.
// Codewords failing the syndrome check are dropped and counted, saturating at 16'hFFFF.
module sntc_ldpc_cword_serializer #(
    parameter int NN = 208,
    parameter int MM = 168,
    parameter int OW = 16,
    localparam int BEATS = (NN + OW - 1) / OW,
    localparam int BW = $clog2(BEATS),
    localparam int LW = $clog2(NN + 1)
) (
    input  logic          clk,
    input  logic          clr,
    input  logic [NN-1:0] cw_in,
    input  logic          cw_in_valid,
    input  logic          cw_in_chk,
    output logic          cw_in_ready,
    output logic [OW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last,
    output logic [BW-1:0] out_idx,
    output logic [15:0]   drop_cnt,
    output logic [LW-1:0] msg_len
);

    // Hold register is widened to a whole number of beats so the tail beat zero-pads.
    localparam int PW = BEATS * OW;

    typedef enum logic {IDLE, SEND} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   hold_q, hold_d;
    logic [BW-1:0]   idx_q, idx_d;
    logic [15:0]     drop_q, drop_d;

    logic beat_hs;
    logic last_hs;
    logic accept;

    assign out_valid   = (state_q == SEND);
    assign out_last    = (state_q == SEND) && (idx_q == BW'(BEATS - 1));
    assign out_idx     = idx_q;
    assign out_data    = hold_q[idx_q*OW +: OW];
    assign drop_cnt    = drop_q;
    assign msg_len     = LW'(NN - MM);

    assign beat_hs     = out_valid & out_ready;
    assign last_hs     = beat_hs & out_last;
    assign cw_in_ready = (state_q == IDLE) | last_hs;
    assign accept      = cw_in_valid & cw_in_ready;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        idx_d   = idx_q;
        drop_d  = drop_q;

        if (beat_hs && !out_last) begin
            idx_d = idx_q + BW'(1);
        end
        if (last_hs) begin
            state_d = IDLE;
        end

        // A passing codeword taken on the last beat overrides the drop to IDLE.
        if (accept) begin
            if (cw_in_chk) begin
                hold_d  = PW'(cw_in);
                idx_d   = '0;
                state_d = SEND;
            end else if (drop_q != 16'hFFFF) begin
                drop_d = drop_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= IDLE;
            hold_q  <= '0;
            idx_q   <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            idx_q   <= idx_d;
            drop_q  <= drop_d;
        end
    end

endmodule

// File: tb/tb_sntc_ldpc_cword_serializer.sv
// Directed bench for the LDPC codeword serializer, including a NN=200 padding instance.
module tb_sntc_ldpc_cword_serializer;

    logic         clk = 1'b0;
    logic         clr;
    logic [207:0] cw_in;
    logic         cw_in_valid;
    logic         cw_in_chk;
    logic         cw_in_ready;
    logic [15:0]  out_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;
    logic [3:0]   out_idx;
    logic [15:0]  drop_cnt;
    logic [7:0]   msg_len;

    logic         p_clr;
    logic [199:0] p_cw_in;
    logic         p_cw_in_valid;
    logic         p_cw_in_chk;
    logic         p_cw_in_ready;
    logic [15:0]  p_out_data;
    logic         p_out_valid;
    logic         p_out_ready;
    logic         p_out_last;
    logic [3:0]   p_out_idx;
    logic [15:0]  p_drop_cnt;
    logic [7:0]   p_msg_len;

    int tests = 0;
    int fails = 0;

    logic [15:0] exp_beat [13];

    always #5 clk = ~clk;

    sntc_ldpc_cword_serializer dut (
        .clk(clk), .clr(clr), .cw_in(cw_in), .cw_in_valid(cw_in_valid),
        .cw_in_chk(cw_in_chk), .cw_in_ready(cw_in_ready), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .out_idx(out_idx), .drop_cnt(drop_cnt), .msg_len(msg_len)
    );

    sntc_ldpc_cword_serializer #(.NN(200), .MM(168), .OW(16)) dut_pad (
        .clk(clk), .clr(p_clr), .cw_in(p_cw_in), .cw_in_valid(p_cw_in_valid),
        .cw_in_chk(p_cw_in_chk), .cw_in_ready(p_cw_in_ready), .out_data(p_out_data),
        .out_valid(p_out_valid), .out_ready(p_out_ready), .out_last(p_out_last),
        .out_idx(p_out_idx), .drop_cnt(p_drop_cnt), .msg_len(p_msg_len)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int b;
        int cyc;

        clr = 1'b1; cw_in = '0; cw_in_valid = 1'b0; cw_in_chk = 1'b0; out_ready = 1'b1;
        p_clr = 1'b1; p_cw_in = '0; p_cw_in_valid = 1'b0; p_cw_in_chk = 1'b0; p_out_ready = 1'b1;
        tick();
        clr = 1'b0; p_clr = 1'b0;
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_last", 32'(out_last), 32'd0);
        check("rst_idx", 32'(out_idx), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_ready", 32'(cw_in_ready), 32'd1);
        check("rst_drop", 32'(drop_cnt), 32'd0);
        check("msg_len", 32'(msg_len), 32'd40);

        // Single codeword, bit i = i[0]: every beat is 16'hAAAA.
        for (int i = 0; i < 208; i++) cw_in[i] = 1'(i % 2);
        cw_in_valid = 1'b1; cw_in_chk = 1'b1;
        #1;
        check("single_in_ready", 32'(cw_in_ready), 32'd1);
        tick();
        cw_in_valid = 1'b0;
        for (int k = 0; k < 13; k++) begin
            #1;
            check($sformatf("single_valid_%0d", k), 32'(out_valid), 32'd1);
            check($sformatf("single_data_%0d", k), 32'(out_data), 32'hAAAA);
            check($sformatf("single_idx_%0d", k), 32'(out_idx), 32'(k));
            check($sformatf("single_last_%0d", k), 32'(out_last), 32'(k == 12));
            check($sformatf("single_ready_%0d", k), 32'(cw_in_ready), 32'(k == 12));
            tick();
        end
        check("single_idle_valid", 32'(out_valid), 32'd0);
        check("single_idle_ready", 32'(cw_in_ready), 32'd1);

        // Back-to-back all-ones then all-zeros.
        cw_in = '1; cw_in_valid = 1'b1; cw_in_chk = 1'b1;
        #1;
        check("b2b_ready_c0", 32'(cw_in_ready), 32'd1);
        tick();
        cw_in = '0;
        for (int k = 0; k < 26; k++) begin
            #1;
            check($sformatf("b2b_valid_%0d", k), 32'(out_valid), 32'd1);
            check($sformatf("b2b_data_%0d", k), 32'(out_data), (k < 13) ? 32'hFFFF : 32'h0000);
            check($sformatf("b2b_idx_%0d", k), 32'(out_idx), 32'(k % 13));
            check($sformatf("b2b_ready_%0d", k), 32'(cw_in_ready), 32'(k == 12 || k == 25));
            tick();
            if (k == 12) cw_in_valid = 1'b0;
        end
        check("b2b_idle", 32'(out_valid), 32'd0);

        // Backpressure with distinct beat values.
        for (int k = 0; k < 13; k++) begin
            exp_beat[k] = 16'hC000 | 16'(k * 16'h0111);
            cw_in[k*16 +: 16] = exp_beat[k];
        end
        cw_in_valid = 1'b1; cw_in_chk = 1'b1;
        tick();
        cw_in_valid = 1'b0;
        b = 0; cyc = 0;
        while (b < 13 && cyc < 300) begin
            out_ready = 1'($urandom_range(0, 1));
            #1;
            check($sformatf("bp_valid_c%0d", cyc), 32'(out_valid), 32'd1);
            check($sformatf("bp_data_c%0d", cyc), 32'(out_data), 32'(exp_beat[b]));
            check($sformatf("bp_idx_c%0d", cyc), 32'(out_idx), 32'(b));
            check($sformatf("bp_ready_c%0d", cyc), 32'(cw_in_ready), 32'(out_ready && b == 12));
            if (out_ready) b++;
            tick();
            cyc++;
        end
        check("bp_done_in_budget", 32'(b), 32'd13);
        out_ready = 1'b1;
        #1;
        check("bp_idle", 32'(out_valid), 32'd0);

        // Syndrome failures in IDLE.
        cw_in = '1; cw_in_valid = 1'b1; cw_in_chk = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("syn_novalid_%0d", k), 32'(out_valid), 32'd0);
            tick();
        end
        cw_in_valid = 1'b0;
        #1;
        check("syn_novalid_after", 32'(out_valid), 32'd0);
        check("syn_drop3", 32'(drop_cnt), 32'd3);
        for (int i = 0; i < 208; i++) cw_in[i] = 1'((i + 1) % 2);
        cw_in_valid = 1'b1; cw_in_chk = 1'b1;
        tick();
        cw_in_valid = 1'b0;
        for (int k = 0; k < 13; k++) begin
            if (k == 12) begin
                cw_in = '1; cw_in_valid = 1'b1; cw_in_chk = 1'b0;
            end
            #1;
            check($sformatf("syn_data_%0d", k), 32'(out_data), 32'h5555);
            check($sformatf("syn_idx_%0d", k), 32'(out_idx), 32'(k));
            tick();
        end
        cw_in_valid = 1'b0; cw_in_chk = 1'b1;
        #1;
        check("syn_last_drop_idle", 32'(out_valid), 32'd0);
        check("syn_drop4", 32'(drop_cnt), 32'd4);

        // Reset during beat 5.
        cw_in = '1; cw_in_valid = 1'b1; cw_in_chk = 1'b1;
        tick();
        cw_in_valid = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        check("mid_idx5", 32'(out_idx), 32'd5);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        #1;
        check("mid_valid", 32'(out_valid), 32'd0);
        check("mid_drop", 32'(drop_cnt), 32'd0);
        check("mid_ready", 32'(cw_in_ready), 32'd1);
        check("mid_idx0", 32'(out_idx), 32'd0);
        cw_in_valid = 1'b1;
        tick();
        cw_in_valid = 1'b0;
        #1;
        check("mid_restart_valid", 32'(out_valid), 32'd1);
        check("mid_restart_idx", 32'(out_idx), 32'd0);
        check("mid_restart_data", 32'(out_data), 32'hFFFF);

        // NN=200 padding: tail beat carries only 8 codeword bits.
        p_cw_in = '1; p_cw_in_valid = 1'b1; p_cw_in_chk = 1'b1;
        tick();
        p_cw_in_valid = 1'b0;
        for (int k = 0; k < 13; k++) begin
            #1;
            check($sformatf("pad_data_%0d", k), 32'(p_out_data), (k == 12) ? 32'h00FF : 32'hFFFF);
            check($sformatf("pad_last_%0d", k), 32'(p_out_last), 32'(k == 12));
            tick();
        end
        check("pad_idle", 32'(p_out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
